// File: rtl/prio_code_event_fifo.sv
// Debounces the priority-encoder code and queues each committed change in a
// first-word-fall-through FIFO so a slow reader sees the ordered transition history.
module prio_code_event_fifo #(
  parameter int          DEPTH         = 8,
  parameter int          STABLE_CYCLES = 4,
  parameter logic [7:0]  IDLE_CODE     = 8'hF0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic [7:0]                 code_in,
  input  logic                       rd_en,
  input  logic                       ovf_clr,
  output logic [4:0]                 rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  localparam int         PW       = $clog2(DEPTH);
  localparam int         LW       = PW + 1;
  localparam int         CW       = $clog2(STABLE_CYCLES) + 1;
  localparam logic [4:0] IDLE_ENT = 5'h10;

  // Anything outside 0..15 collapses to the idle entry, keeping index 0 distinct.
  function automatic logic [4:0] decode(input logic [7:0] c);
    if (c == IDLE_CODE) return IDLE_ENT;
    if (c < 8'd16)      return {1'b0, c[3:0]};
    return IDLE_ENT;
  endfunction

  logic [4:0]    dec;
  logic [4:0]    cand_q;
  logic [4:0]    comm_q;
  logic [CW-1:0] cnt_q;
  logic          push;
  logic          pop;
  logic          wr_ok;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [4:0]    mem [DEPTH];

  assign dec  = decode(code_in);
  assign push = ena && (dec == cand_q) && (cand_q != comm_q) &&
                (cnt_q == CW'(STABLE_CYCLES - 1));

  // Debounce: candidate must be seen STABLE_CYCLES times in a row before commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q <= IDLE_ENT;
      comm_q <= IDLE_ENT;
      cnt_q  <= '0;
    end else if (ena) begin
      if (dec != cand_q) begin
        cand_q <= dec;
        cnt_q  <= CW'(1);
      end else if (cand_q != comm_q) begin
        if (push) begin
          comm_q <= cand_q;
          cnt_q  <= '0;
        end else begin
          cnt_q  <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));
  assign pop   = rd_en && !empty;
  // A push into a full FIFO is only accepted when the same edge frees a slot.
  assign wr_ok = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      if (wr_ok && !pop)      level <= level + LW'(1);
      else if (!wr_ok && pop) level <= level - LW'(1);
      if (push && !wr_ok)     overflow <= 1'b1;
      else if (ovf_clr)       overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= cand_q;
  end

  assign rd_data = empty ? 5'h00 : mem[rd_ptr];

endmodule
